// File: rtl/async_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the async event arbiter.
package async_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int N_REQ_MAX       = 16;

    // First set bit searching upward from ptr+1, wrapping at n; returns ptr when nothing is pending.
    function automatic logic [3:0] rr_pick(input logic [N_REQ_MAX-1:0] pend,
                                           input logic [3:0]           ptr,
                                           input int                   n);
        logic [3:0] pick;
        logic [3:0] idx;
        pick = ptr;
        for (int off = n; off >= 1; off--) begin
            idx = 4'((int'(ptr) + off) % n);
            if (pend[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Single-bit multi-flop synchronizer followed by a rising-edge detector.
module sync_edge_det
    import async_arb_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic outclk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sync flops are reset too, so a line held high through reset shows up as one fresh edge.
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling its pre-edge input.
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/async_event_arbiter.sv
// Synchronizes N event lines, latches edges as pending requests and grants them round-robin.
// Optional ASYNC_ARB_OVERFLOW_EN enables the sticky per-line lost-edge flags.
module async_event_arbiter
    import async_arb_pkg::*;
#(
    parameter  int N_REQ       = N_REQ_DEF,
    parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int ID_W        = $clog2(N_REQ)
) (
    input  logic             outclk,
    input  logic             reset,
    input  logic [N_REQ-1:0] async_sig,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    input  logic             grant_ready,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overflow,
    input  logic             clr_overflow
);

    logic [N_REQ-1:0] edge_vec;
    logic [N_REQ-1:0] clr_vec;
    logic             handshake;
    arb_state_t       state, state_next;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_next;
    logic [ID_W-1:0]  grant_id_next;
    logic [3:0]       pick;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .outclk    (outclk),
            .reset     (reset),
            .async_in  (async_sig[i]),
            .edge_pulse(edge_vec[i])
        );
    end

    assign grant_valid = (state == GRANT);
    assign handshake   = grant_valid & grant_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        clr_vec = '0;
        if (handshake) clr_vec[grant_id] = 1'b1;
    end

    // A new edge outranks the handshake clear on the same line.
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~clr_vec) | edge_vec;
    end

`ifdef ASYNC_ARB_OVERFLOW_EN
    logic [N_REQ-1:0] ovf_set;
    assign ovf_set = edge_vec & pending & ~clr_vec;

    always_ff @(posedge outclk or posedge reset) begin
        if (reset) overflow <= '0;
        else       overflow <= (clr_overflow ? '0 : overflow) | ovf_set;
    end
`else
    logic unused_clr_overflow;
    assign unused_clr_overflow = clr_overflow;
    assign overflow            = '0;
`endif

    assign pick = rr_pick(N_REQ_MAX'(pending), 4'(rr_ptr), N_REQ);

    always_comb begin
        state_next    = state;
        grant_id_next = grant_id;
        rr_ptr_next   = rr_ptr;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    state_next    = GRANT;
                    grant_id_next = pick[ID_W-1:0];
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_id;
                end
            end
        endcase
    end

    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
        end else begin
            state    <= state_next;
            grant_id <= grant_id_next;
            rr_ptr   <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_async_event_arbiter.sv
// Directed, table-driven bench for async_event_arbiter (default N_REQ=4, SYNC_STAGES=2).
`timescale 1ns/1ps
module tb_async_event_arbiter;
    import async_arb_pkg::*;

    localparam int N = 4;

    logic         outclk = 1'b0;
    logic         reset;
    logic [N-1:0] async_sig;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         grant_ready;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;
    logic         clr_overflow;

    int half_ns = 5;
    int checks  = 0;
    int errors  = 0;

    always #(half_ns) outclk = ~outclk;

    async_event_arbiter #(.N_REQ(N), .SYNC_STAGES(2)) dut (
        .outclk      (outclk),
        .reset       (reset),
        .async_sig   (async_sig),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_ready (grant_ready),
        .pending     (pending),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] sig;
        logic         rdy;
        logic         exp_v;
        logic [1:0]   exp_id;
        logic [N-1:0] exp_p;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

`ifdef ASYNC_ARB_OVERFLOW_EN
    localparam logic [N-1:0] EXP_OVF1 = 4'b0010;
`else
    localparam logic [N-1:0] EXP_OVF1 = 4'b0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge outclk);
        #1;
    endtask

    task automatic reset_dut();
        grant_ready  = 1'b0;
        clr_overflow = 1'b0;
        reset        = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n = 0;
        while (!grant_valid && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(grant_valid), 32'd1);
    endtask

    task automatic count_handshakes(input int cycles, output int hs, output logic [1:0] last_id);
        hs      = 0;
        last_id = '0;
        repeat (cycles) begin
            if (grant_valid && grant_ready) begin
                hs++;
                last_id = grant_id;
            end
            tick();
        end
    endtask

    initial begin
        int         hs;
        logic [1:0] hid;
        int         xbad;
        int         rbad;

        reset        = 1'b1;
        async_sig    = '0;
        grant_ready  = 1'b0;
        clr_overflow = 1'b0;

        // Line 2 latency and handshake, then lines 0/1/3 together and a repeat on line 0.
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[1]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[3]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100};
        vecs[4]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
        vecs[5]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[7]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[8]  = '{1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[9]  = '{1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011};
        vecs[10] = '{1'b0, 4'b1010, 1'b1, 1'b1, 2'd0, 4'b1011};
        vecs[11] = '{1'b0, 4'b1010, 1'b1, 1'b0, 2'd0, 4'b1010};
        vecs[12] = '{1'b0, 4'b1010, 1'b1, 1'b1, 2'd1, 4'b1010};
        vecs[13] = '{1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b1000};
        vecs[14] = '{1'b0, 4'b1011, 1'b1, 1'b1, 2'd3, 4'b1000};
        vecs[15] = '{1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b0001};
        vecs[16] = '{1'b0, 4'b1011, 1'b1, 1'b1, 2'd0, 4'b0001};
        vecs[17] = '{1'b0, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000};

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) reset_dut();
            async_sig   = vecs[i].sig;
            grant_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) check($sformatf("vec%0d_id", i), 32'(grant_id), 32'(vecs[i].exp_id));
            check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_p));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'd0);
        end

        // Second edge on line 1 while it is still pending and unserved.
        async_sig = '0;
        reset_dut();
        async_sig = 4'b0010; repeat (2) tick();
        async_sig = 4'b0000; repeat (2) tick();
        async_sig = 4'b0010; repeat (2) tick();
        async_sig = 4'b0000; repeat (3) tick();
        check("ovf_valid", 32'(grant_valid), 32'd1);
        check("ovf_id", 32'(grant_id), 32'd1);
        check("ovf_pending", 32'(pending), 32'b0010);
        check("ovf_flag", 32'(overflow), 32'(EXP_OVF1));
        grant_ready = 1'b1;
        count_handshakes(8, hs, hid);
        check("ovf_grant_count", 32'(hs), 32'd1);
        check("ovf_pending_after", 32'(pending), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'(EXP_OVF1));
        clr_overflow = 1'b1; tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // New edge on line 1 lands on the same edge as line 1's handshake.
        grant_ready = 1'b0;
        reset_dut();
        async_sig = 4'b0010;
        wait_grant("same_first", 10);
        check("same_first_id", 32'(grant_id), 32'd1);
        async_sig = 4'b0000; repeat (2) tick();
        async_sig = 4'b0010; repeat (2) tick();
        grant_ready = 1'b1; tick();
        grant_ready = 1'b0;
        check("same_pending", 32'(pending), 32'b0010);
        check("same_overflow", 32'(overflow), 32'd0);
        check("same_dead_cycle", 32'(grant_valid), 32'd0);
        tick();
        check("same_second_valid", 32'(grant_valid), 32'd1);
        check("same_second_id", 32'(grant_id), 32'd1);
        grant_ready = 1'b1; tick();
        check("same_second_done", 32'(pending), 32'd0);

        // Asynchronous reset while granting line 3; line 3 stays high across release.
        grant_ready = 1'b0;
        async_sig   = 4'b0000;
        reset_dut();
        async_sig = 4'b1000;
        wait_grant("rst_grant", 10);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(grant_valid), 32'd0);
        check("rst_async_pending", 32'(pending), 32'd0);
        #2 reset = 1'b0;
        tick();
        grant_ready = 1'b1;
        count_handshakes(12, hs, hid);
        check("rst_regrant_count", 32'(hs), 32'd1);
        check("rst_regrant_id", 32'(hid), 32'd3);

        // Line 0 toggles every 1 ns against a 14 ns clock; line 1 toggles slowly to keep traffic flowing.
        grant_ready = 1'b0;
        async_sig   = 4'b0000;
        reset_dut();
        half_ns = 7;
        tick();
        grant_ready = 1'b1;
        xbad = 0;
        rbad = 0;
        hs   = 0;
        fork
            repeat (2000) #1 async_sig[0] = ~async_sig[0];
            repeat (66) #30 async_sig[1] = ~async_sig[1];
        join_none
        repeat (143) begin
            if (grant_valid && grant_ready) hs++;
            tick();
            if ($isunknown({grant_valid, grant_id, pending, overflow})) xbad++;
            if (int'(grant_id) >= N) rbad++;
        end
        check("tog_no_x", 32'(xbad), 32'd0);
        check("tog_id_range", 32'(rbad), 32'd0);
        check("tog_progress", 32'(hs >= 10), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
